// File: rtl/cam_pattern_gen_if.sv
// Camera-side bus of the synthetic OV7670-style source: run/pattern controls in, sync, pixel and frame status out.
interface cam_pattern_gen_if;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [11:0] solid_rgb;
    logic        CAM_VSYNC;
    logic        CAM_HREF;
    logic [7:0]  CAM_px_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    modport master (
        input  en, pattern_sel, solid_rgb,
        output CAM_VSYNC, CAM_HREF, CAM_px_data, frame_done, frame_cnt
    );

    modport slave (
        output en, pattern_sel, solid_rgb,
        input  CAM_VSYNC, CAM_HREF, CAM_px_data, frame_done, frame_cnt
    );
endinterface

// File: rtl/cam_pattern_gen.sv
// Synthetic camera source: VSYNC/HREF framing with RGB444 two-byte pixels from selectable test patterns.
//  state  | meaning
//  IDLE   | stopped, all outputs low, waits for en
//  VSYNC  | frame sync high for VS_W cycles, pattern controls latched on entry
//  VBP    | vertical back porch, VB_W cycles
//  LINE   | HREF high, 2*H_PIX bytes of one line
//  HBLANK | HREF low, HB_W cycles after every line
//  VFP    | vertical front porch, VF_W cycles (VF_W >= 2), frame_done on last cycle
module cam_pattern_gen #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int VS_W    = 6,
    parameter int VB_W    = 20,
    parameter int HB_W    = 24,
    parameter int VF_W    = 20
) (
    input  logic              CAM_PCLK,
    input  logic              rst,
    cam_pattern_gen_if.master bus
);
    localparam logic [15:0] T_VS   = 16'(VS_W - 1);
    localparam logic [15:0] T_VB   = 16'(VB_W - 1);
    localparam logic [15:0] T_LINE = 16'(2 * H_PIX - 1);
    localparam logic [15:0] T_HB   = 16'(HB_W - 1);
    localparam logic [15:0] T_VF   = 16'(VF_W - 1);
    localparam logic [9:0]  BAR_W  = 10'(H_PIX / 8);
    localparam logic [9:0]  LAST_Y = 10'(V_LINES - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP} state_t;

    state_t      r_state;
    logic [15:0] r_tmr;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [11:0] r_idx;
    logic        r_ph;
    logic [7:0]  r_lo;
    logic [1:0]  r_sel;
    logic [11:0] r_solid;
    logic        r_vsync;
    logic        r_href;
    logic [7:0]  r_data;
    logic        r_done;
    logic [7:0]  r_fcnt;

    logic [3:0]  w_y0;
    logic [11:0] w_first;
    logic [11:0] w_nxt;

    function automatic logic [11:0] pix(input logic [9:0] x, input logic [3:0] y4,
                                        input logic [11:0] idx, input logic [1:0] sel,
                                        input logic [11:0] solid);
        logic [2:0]  b;
        logic [11:0] v;
        b = 3'(x / BAR_W);
        case (sel)
            2'd0:    v = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
            2'd1:    v = solid;
            2'd2:    v = {x[3:0], y4, x[7:4]};
            default: v = idx;
        endcase
        return v;
    endfunction

    // First pixel of the line about to start; r_idx already points past the previous line.
    assign w_y0    = (r_state == S_HBLANK) ? r_y[3:0] + 4'd1 : r_y[3:0];
    assign w_first = pix(10'd0, w_y0, r_idx, r_sel, r_solid);
    assign w_nxt   = pix(r_x + 10'd1, r_y[3:0], r_idx + 12'd1, r_sel, r_solid);

    always_ff @(posedge CAM_PCLK) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_ph    <= 1'b0;
            r_lo    <= '0;
            r_sel   <= '0;
            r_solid <= '0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_state <= S_VSYNC;
                        r_vsync <= 1'b1;
                        r_tmr   <= T_VS;
                        r_y     <= '0;
                        r_idx   <= '0;
                        r_sel   <= bus.pattern_sel;
                        r_solid <= bus.solid_rgb;
                    end
                end
                S_VSYNC: begin
                    if (r_tmr == 16'd0) begin
                        r_state <= S_VBP;
                        r_vsync <= 1'b0;
                        r_tmr   <= T_VB;
                    end else begin
                        r_tmr <= r_tmr - 16'd1;
                    end
                end
                S_VBP, S_HBLANK: begin
                    if (r_tmr != 16'd0) begin
                        r_tmr <= r_tmr - 16'd1;
                    end else if (r_state == S_HBLANK && r_y == LAST_Y) begin
                        r_state <= S_VFP;
                        r_tmr   <= T_VF;
                    end else begin
                        if (r_state == S_HBLANK) r_y <= r_y + 10'd1;
                        r_state <= S_LINE;
                        r_href  <= 1'b1;
                        r_tmr   <= T_LINE;
                        r_x     <= '0;
                        r_ph    <= 1'b0;
                        r_data  <= {4'h0, w_first[11:8]};
                        r_lo    <= w_first[7:0];
                    end
                end
                S_LINE: begin
                    if (r_tmr == 16'd0) begin
                        r_state <= S_HBLANK;
                        r_href  <= 1'b0;
                        r_data  <= '0;
                        r_idx   <= r_idx + 12'd1;
                        r_tmr   <= T_HB;
                    end else begin
                        r_tmr <= r_tmr - 16'd1;
                        if (!r_ph) begin
                            r_data <= r_lo;
                            r_ph   <= 1'b1;
                        end else begin
                            r_x    <= r_x + 10'd1;
                            r_idx  <= r_idx + 12'd1;
                            r_ph   <= 1'b0;
                            r_data <= {4'h0, w_nxt[11:8]};
                            r_lo   <= w_nxt[7:0];
                        end
                    end
                end
                S_VFP: begin
                    if (r_tmr != 16'd0) begin
                        r_tmr <= r_tmr - 16'd1;
                        if (r_tmr == 16'd1) begin
                            r_done <= 1'b1;
                            r_fcnt <= r_fcnt + 8'd1;
                        end
                    end else if (bus.en) begin
                        r_state <= S_VSYNC;
                        r_vsync <= 1'b1;
                        r_tmr   <= T_VS;
                        r_y     <= '0;
                        r_idx   <= '0;
                        r_sel   <= bus.pattern_sel;
                        r_solid <= bus.solid_rgb;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.CAM_VSYNC   = r_vsync;
    assign bus.CAM_HREF    = r_href;
    assign bus.CAM_px_data = r_data;
    assign bus.frame_done  = r_done;
    assign bus.frame_cnt   = r_fcnt;
endmodule
